// File: rtl/t03_wb_responder.sv
// t03_wb_responder
//   Wishbone-style target that serves a word-addressed scratch RAM window.
//   Each request is captured once in IDLE, held for WAIT_CYCLES wait states,
//   and answered with a single-cycle ack; ACK always returns to IDLE so acks
//   can never be adjacent. Out-of-window accesses complete normally but read
//   as zero and set a sticky error flag.
module t03_wb_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_addri,
  input  logic [31:0] wb_di,
  input  logic [3:0]  wb_sel,
  input  logic        wb_wen,
  input  logic        wb_ren,
  output logic [31:0] wb_do,
  output logic        wb_ack,
  output logic        err_flag
);

  localparam int          AW        = $clog2(DEPTH);
  // Window bounds kept in 33 bits so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  // Scratch RAM; deliberately has no reset so contents survive rst.
  logic [31:0] mem [DEPTH];

  // Operands of the transaction being completed. In IDLE the live bus is
  // used (a zero-wait build completes on the capture edge itself); otherwise
  // the captured copies are used so later bus changes have no effect.
  logic          in_idle;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_data;
  logic [3:0]    cur_sel;
  logic          cur_wr;
  logic          in_win;
  logic [AW-1:0] cur_idx;
  logic          enter_ack;

  // Operand selection and address decode for the active transaction.
  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    cur_addr = in_idle ? wb_addri : addr_q;
    cur_data = in_idle ? wb_di    : data_q;
    cur_sel  = in_idle ? wb_sel   : sel_q;
    cur_wr   = in_idle ? wb_wen   : wr_q;
    in_win   = ({1'b0, cur_addr} >= WIN_LO) && ({1'b0, cur_addr} < WIN_HI);
    cur_idx  = AW'((cur_addr - BASE_ADDR) >> 2);
  end

  // Next-state logic: capture in IDLE, count wait states, complete on ACK entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    enter_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_wen || wb_ren) begin
          addr_d = wb_addri;
          data_d = wb_di;
          sel_d  = wb_sel;
          wr_d   = wb_wen;
          if (WAIT_CYCLES == 0) begin
            enter_ack = 1'b1;
            state_d   = ST_ACK;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_ack = 1'b1;
          state_d   = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enter_ack) begin
      ack_d = 1'b1;
      if (!in_win) begin
        err_d = 1'b1;
      end
      if (!cur_wr) begin
        rdata_d = in_win ? mem[cur_idx] : 32'h0;
      end
    end
  end

  // Control state and registered outputs; async reset drops any pending op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      sel_q   <= 4'h0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane RAM write on the edge that enters ACK.
  always_ff @(posedge clk) begin
    if (!rst && enter_ack && cur_wr && in_win) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_sel[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
        end
      end
    end
  end

  assign wb_do    = rdata_q;
  assign wb_ack   = ack_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_t03_wb_responder.sv
// tb_t03_wb_responder
//   Two responder builds (two wait states / zero wait states) driven through a
//   shared stimulus port, checked against a word-array reference model.
module tb_t03_wb_responder;

  localparam logic [31:0] BASE2 = 32'h0000_1000;
  localparam logic [31:0] BASE0 = 32'hFFFF_FC00;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        use0 = 1'b0;
  logic        t_wen = 1'b0, t_ren = 1'b0;
  logic [31:0] t_addr = 32'h0, t_di = 32'h0;
  logic [3:0]  t_sel = 4'h0;

  logic        a2_wen, a2_ren, a0_wen, a0_ren;
  logic [31:0] a2_addr, a2_di, a0_addr, a0_di;
  logic [3:0]  a2_sel, a0_sel;
  logic [31:0] do2, do0;
  logic        ack2, ack0, err2, err0;
  logic [31:0] cur_do;
  logic        cur_ack, cur_err;

  assign a2_wen  = use0 ? 1'b0  : t_wen;
  assign a2_ren  = use0 ? 1'b0  : t_ren;
  assign a2_addr = use0 ? 32'h0 : t_addr;
  assign a2_di   = use0 ? 32'h0 : t_di;
  assign a2_sel  = use0 ? 4'h0  : t_sel;
  assign a0_wen  = use0 ? t_wen  : 1'b0;
  assign a0_ren  = use0 ? t_ren  : 1'b0;
  assign a0_addr = use0 ? t_addr : 32'h0;
  assign a0_di   = use0 ? t_di   : 32'h0;
  assign a0_sel  = use0 ? t_sel  : 4'h0;
  assign cur_do  = use0 ? do0  : do2;
  assign cur_ack = use0 ? ack0 : ack2;
  assign cur_err = use0 ? err0 : err2;

  t03_wb_responder #(.BASE_ADDR(BASE2), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wb_addri(a2_addr), .wb_di(a2_di), .wb_sel(a2_sel),
    .wb_wen(a2_wen), .wb_ren(a2_ren), .wb_do(do2), .wb_ack(ack2), .err_flag(err2)
  );

  t03_wb_responder #(.BASE_ADDR(BASE0), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_addri(a0_addr), .wb_di(a0_di), .wb_sel(a0_sel),
    .wb_wen(a0_wen), .wb_ren(a0_ren), .wb_do(do0), .wb_ack(ack0), .err_flag(err0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one word array per build plus last read value and error flag.
  logic [31:0] mdl_mem [2][DEPTH];
  bit          mdl_vld [2][DEPTH];
  logic [31:0] mdl_do  [2];
  bit          mdl_do_vld [2];
  bit          mdl_err [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE2;
  endfunction

  // One bus transaction on build d (0 = zero-wait, 2 = two-wait).
  task automatic run_txn(input int d, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input bit hold, input bit scramble,
                         output logic [31:0] rdata);
    int lat;
    int exp_lat;
    int idx;
    int m;
    bit acked;
    bit inwin;
    longint unsigned a, lo;
    m       = (d == 0) ? 0 : 1;
    exp_lat = (d == 0) ? 1 : 3;
    @(negedge clk);
    use0   = (d == 0);
    t_wen  = we;
    t_ren  = re;
    t_addr = addr;
    t_di   = data;
    t_sel  = sel;
    lat    = 0;
    acked  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (cur_ack) begin
        acked = 1'b1;
        break;
      end
      if (lat == 1 && scramble) begin
        t_addr = $urandom;
        t_di   = $urandom;
        t_sel  = 4'($urandom);
        t_wen  = 1'b0;
        t_ren  = 1'b0;
      end
    end
    chk("ack_latency", 32'(lat), 32'(exp_lat));
    // Model update from the request as issued.
    a     = {32'd0, addr};
    lo    = {32'd0, base_of(d)};
    inwin = (a >= lo) && (a < lo + 64'(4 * DEPTH));
    idx   = inwin ? int'((a - lo) >> 2) : 0;
    if (we) begin
      if (inwin) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) mdl_mem[m][idx][8*b +: 8] = data[8*b +: 8];
        end
        if (sel == 4'hF) mdl_vld[m][idx] = 1'b1;
      end
    end else begin
      if (inwin) begin
        mdl_do[m]     = mdl_mem[m][idx];
        mdl_do_vld[m] = mdl_vld[m][idx];
      end else begin
        mdl_do[m]     = 32'h0;
        mdl_do_vld[m] = 1'b1;
      end
    end
    if (!inwin) mdl_err[m] = 1'b1;
    rdata = cur_do;
    if (acked && mdl_do_vld[m]) chk("wb_do", cur_do, mdl_do[m]);
    chk("err_flag", {31'd0, cur_err}, {31'd0, mdl_err[m]});
    $display("txn dut%0d wen=%0b ren=%0b addr=%h di=%h sel=%b -> do=%h lat=%0d err=%0b",
             d, we, re, addr, data, sel, cur_do, lat, cur_err);
    if (!hold) begin
      t_wen = 1'b0;
      t_ren = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("ack_one_cycle", {31'd0, cur_ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    logic        we, re;
    int          r;

    for (int k = 0; k < 2; k++) begin
      mdl_do[k]     = 32'h0;
      mdl_do_vld[k] = 1'b1;
      mdl_err[k]    = 1'b0;
      for (int w = 0; w < DEPTH; w++) mdl_vld[k][w] = 1'b0;
    end

    // Reset acts immediately, without waiting for a clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_ack", {31'd0, ack2}, 32'd0);
    chk("rst_do", do2, 32'h0);
    chk("rst_err", {31'd0, err2}, 32'd0);
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("idle_ack", {31'd0, ack2}, 32'd0);
    end

    // Fill the two-wait build's RAM so every later read has a known answer.
    for (int w = 0; w < DEPTH; w++) begin
      run_txn(2, 1'b1, 1'b0, BASE2 + 32'(4 * w), $urandom, 4'hF, 1'b0, 1'b0, rd);
    end

    // Full-word write and read back.
    run_txn(2, 1'b1, 1'b0, BASE2 + 32'h10, 32'h1234_5678, 4'hF, 1'b0, 1'b0, rd);
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, rd);
    chk("rd_full", rd, 32'h1234_5678);

    // Partial lanes.
    run_txn(2, 1'b1, 1'b0, BASE2 + 32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, rd);
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, rd);
    chk("rd_lanes", rd, 32'h12BB_56DD);

    // Just past the window end, then a normal read.
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'(4 * DEPTH), 32'h0, 4'hF, 1'b0, 1'b0, rd);
    chk("oow_do", rd, 32'h0);
    chk("oow_err", {31'd0, err2}, 32'd1);
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, rd);
    chk("after_oow", rd, 32'h12BB_56DD);
    chk("err_sticky", {31'd0, err2}, 32'd1);

    // Read request held across three transactions.
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'h20, 32'h0, 4'hF, 1'b1, 1'b0, rd);
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'h24, 32'h0, 4'hF, 1'b1, 1'b0, rd);
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, rd);
    chk("held_rd3", rd, 32'h12BB_56DD);

    // Reset during the wait states of a write to word 3.
    @(negedge clk);
    use0   = 1'b0;
    t_wen  = 1'b1;
    t_ren  = 1'b0;
    t_addr = BASE2 + 32'hC;
    t_di   = 32'hFFFF_FFFF;
    t_sel  = 4'hF;
    @(posedge clk);
    #1;
    chk("abort_no_ack", {31'd0, ack2}, 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    t_wen = 1'b0;
    #1;
    chk("abort_rst_ack", {31'd0, ack2}, 32'd0);
    chk("abort_rst_err", {31'd0, err2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mdl_do[k]     = 32'h0;
      mdl_do_vld[k] = 1'b1;
      mdl_err[k]    = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_quiet", {31'd0, ack2}, 32'd0);
    end
    run_txn(2, 1'b0, 1'b1, BASE2 + 32'hC, 32'h0, 4'hF, 1'b0, 1'b0, rd);
    chk("abort_word3", rd, mdl_mem[1][3]);

    // Randomized traffic, sometimes changing the bus right after capture.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       addr = BASE2 - 32'd1 - 32'($urandom_range(0, 15));
        1:       addr = BASE2 + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
        2:       addr = $urandom;
        default: addr = BASE2 + 32'($urandom_range(0, 4 * DEPTH - 1));
      endcase
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (!we && !re) re = 1'b1;
      run_txn(2, we, re, addr, $urandom, 4'($urandom), 1'b0, 1'($urandom_range(0, 1)), rd);
    end

    // Zero-wait build: both enables means write; window reaches 0xFFFFFFFF.
    run_txn(0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, rd);
    chk("w0_do_kept", rd, 32'h0);
    run_txn(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 4'h0, 1'b0, 1'b0, rd);
    chk("w0_rd_top", rd, 32'hCAFE_F00D);
    chk("w0_err_clear", {31'd0, err0}, 32'd0);
    run_txn(0, 1'b0, 1'b1, BASE0 - 32'd4, 32'h0, 4'hF, 1'b0, 1'b0, rd);
    chk("w0_below", rd, 32'h0);
    chk("w0_err_set", {31'd0, err0}, 32'd1);
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 7);
      case (r)
        0:       addr = BASE0 - 32'd1 - 32'($urandom_range(0, 15));
        1:       addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: addr = BASE0 + 32'($urandom_range(0, 63));
      endcase
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (!we && !re) re = 1'b1;
      run_txn(0, we, re, addr, $urandom, (r > 3) ? 4'hF : 4'($urandom), 1'b0, 1'b0, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
